// File: rtl/alu_sequencer.sv
// Instruction sequencer for an external combinational ALU. It keeps a small register
// file and C/Z/V flags, runs one instruction at a time and returns each result on a
// response channel.
module alu_sequencer #(
  parameter int DW          = 8,
  parameter int REG_AW      = 2,
  parameter int EXEC_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic          alu_cin,
  output logic [4:0]    alu_opcode,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_cout,
  input  logic          alu_z,
  input  logic          alu_v,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [2:0]    rsp_flags,
  output logic          rsp_err,
  output logic [1:0]    dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // The producer holds valid and its payload until then; ready never depends on valid.

  localparam int NREG = 2 ** REG_AW;
  localparam logic [4:0] OP_LDI      = 5'd31;
  localparam logic [4:0] OP_LAST_ALU = 5'd26;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RSP  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0]     regs_q [NREG];
  logic              c_q, z_q, v_q;
  logic [3:0]        cnt_q, cnt_d;
  logic [REG_AW-1:0] rd_q, rd_d;

  logic [DW-1:0] alu_a_q, alu_a_d;
  logic [DW-1:0] alu_b_q, alu_b_d;
  logic          alu_cin_q, alu_cin_d;
  logic [4:0]    alu_op_q, alu_op_d;

  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic [2:0]    rsp_flags_q, rsp_flags_d;
  logic          rsp_err_q, rsp_err_d;

  logic              wr_en;
  logic [REG_AW-1:0] wr_addr;
  logic [DW-1:0]     wr_data;
  logic              flags_we;

  logic              handshake;
  logic [4:0]        in_op;
  logic [REG_AW-1:0] in_rd, in_rs1, in_rs2;
  logic [DW-1:0]     in_imm;

  assign in_op  = instr[15:11];
  assign in_rd  = instr[9 +: REG_AW];
  assign in_rs1 = instr[7 +: REG_AW];
  assign in_rs2 = instr[5 +: REG_AW];
  assign in_imm = DW'(instr[7:0]);

  // Ready is also gated by rst_n so it stays low during the whole reset pulse.
  assign instr_ready = rst_n && (state_q == S_IDLE);
  assign handshake   = instr_valid && instr_ready;

  assign rsp_valid  = (state_q == S_RSP);
  assign rsp_data   = rsp_data_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_cin    = alu_cin_q;
  assign alu_opcode = alu_op_q;
  assign dbg_state  = state_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_cin_d   = alu_cin_q;
    alu_op_d    = alu_op_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    flags_we    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (handshake) begin
          rd_d = in_rd;
          if (in_op <= OP_LAST_ALU) begin
            // Operands are snapshotted here, so an rd that aliases rs1/rs2 sees the old value.
            state_d   = S_EXEC;
            cnt_d     = 4'(EXEC_CYCLES - 1);
            alu_a_d   = regs_q[in_rs1];
            alu_b_d   = regs_q[in_rs2];
            alu_cin_d = c_q;
            alu_op_d  = in_op;
          end else if (in_op == OP_LDI) begin
            state_d     = S_RSP;
            wr_en       = 1'b1;
            wr_addr     = in_rd;
            wr_data     = in_imm;
            rsp_data_d  = in_imm;
            rsp_flags_d = {c_q, z_q, v_q};
            rsp_err_d   = 1'b0;
          end else begin
            state_d     = S_RSP;
            rsp_data_d  = '0;
            rsp_flags_d = {c_q, z_q, v_q};
            rsp_err_d   = 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_RSP;
          wr_en       = 1'b1;
          wr_addr     = rd_q;
          wr_data     = alu_result;
          flags_we    = 1'b1;
          rsp_data_d  = alu_result;
          rsp_flags_d = {alu_cout, alu_z, alu_v};
          rsp_err_d   = 1'b0;
          alu_a_d     = '0;
          alu_b_d     = '0;
          alu_cin_d   = 1'b0;
          alu_op_d    = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_cin_q   <= 1'b0;
      alu_op_q    <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      v_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_cin_q   <= alu_cin_d;
      alu_op_q    <= alu_op_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
      if (flags_we) begin
        c_q <= alu_cout;
        z_q <= alu_z;
        v_q <= alu_v;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: two instances (EXEC_CYCLES=1 and 4) share clock and
// reset, each driven by a small behavioural ALU; one instance is selected at a time.
module tb_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        instr_valid;
  logic [15:0] instr;
  logic        rsp_ready;

  int tests_run;
  int tests_failed;

  // instance with EXEC_CYCLES=1
  logic       v1, rr1, ir1, rv1, cin1, cout1, z1, ov1, err1;
  logic [7:0] a1, b1, res1, d1;
  logic [4:0] op1;
  logic [2:0] f1;
  logic [1:0] st1;
  // instance with EXEC_CYCLES=4
  logic       v4, rr4, ir4, rv4, cin4, cout4, z4, ov4, err4;
  logic [7:0] a4, b4, res4, d4;
  logic [4:0] op4;
  logic [2:0] f4;
  logic [1:0] st4;

  assign v1  = instr_valid & ~sel;
  assign v4  = instr_valid & sel;
  assign rr1 = rsp_ready & ~sel;
  assign rr4 = rsp_ready & sel;

  logic       cur_ir, cur_rv, cur_cin, cur_err;
  logic [7:0] cur_a, cur_b, cur_d;
  logic [4:0] cur_op;
  logic [2:0] cur_f;
  logic [1:0] cur_st;
  assign cur_ir  = sel ? ir4  : ir1;
  assign cur_rv  = sel ? rv4  : rv1;
  assign cur_cin = sel ? cin4 : cin1;
  assign cur_err = sel ? err4 : err1;
  assign cur_a   = sel ? a4   : a1;
  assign cur_b   = sel ? b4   : b1;
  assign cur_d   = sel ? d4   : d1;
  assign cur_op  = sel ? op4  : op1;
  assign cur_f   = sel ? f4   : f1;
  assign cur_st  = sel ? st4  : st1;

  alu_sequencer #(.DW(8), .REG_AW(2), .EXEC_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .instr_valid(v1), .instr_ready(ir1), .instr(instr),
    .alu_a(a1), .alu_b(b1), .alu_cin(cin1), .alu_opcode(op1), .alu_result(res1),
    .alu_cout(cout1), .alu_z(z1), .alu_v(ov1), .rsp_valid(rv1), .rsp_ready(rr1),
    .rsp_data(d1), .rsp_flags(f1), .rsp_err(err1), .dbg_state(st1)
  );

  alu_sequencer #(.DW(8), .REG_AW(2), .EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .instr_valid(v4), .instr_ready(ir4), .instr(instr),
    .alu_a(a4), .alu_b(b4), .alu_cin(cin4), .alu_opcode(op4), .alu_result(res4),
    .alu_cout(cout4), .alu_z(z4), .alu_v(ov4), .rsp_valid(rv4), .rsp_ready(rr4),
    .rsp_data(d4), .rsp_flags(f4), .rsp_err(err4), .dbg_state(st4)
  );

  // Behavioural ALU subset: 0 add, 2 add-with-carry, 4 multiply (low byte); returns {cout,z,v,res}.
  function automatic logic [10:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [4:0] op, input logic cin);
    logic [8:0] s;
    logic       v;
    logic [15:0] p;
    s = 9'd0;
    v = 1'b0;
    p = 16'd0;
    case (op)
      5'd0: s = {1'b0, a} + {1'b0, b};
      5'd2: s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      5'd4: begin
        p = {8'd0, a} * {8'd0, b};
        s = {1'b0, p[7:0]};
      end
      default: s = 9'd0;
    endcase
    if (op == 5'd0 || op == 5'd2) v = (a[7] == b[7]) && (s[7] != a[7]);
    return {s[8], (s[7:0] == 8'd0), v, s[7:0]};
  endfunction

  always_comb {cout1, z1, ov1, res1} = alu_model(a1, b1, op1, cin1);
  always_comb {cout4, z4, ov4, res4} = alu_model(a4, b4, op4, cin4);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] enc(input logic [4:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs1, input logic [1:0] rs2);
    return {op, rd, rs1, rs2, 5'd0};
  endfunction

  function automatic logic [15:0] enc_ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {5'd31, rd, 1'b0, imm};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    instr_valid = 1'b0;
    rsp_ready   = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issues one instruction on the selected instance, records what the ALU pins showed
  // while waiting, and (unless hold) accepts the response.
  task automatic issue(input logic [15:0] w, input bit hold,
                       output logic [7:0] d, output logic [2:0] f, output logic e,
                       output int lat, output int n_exec, output bit stable,
                       output logic [7:0] ea, output logic [7:0] eb,
                       output logic [4:0] eop, output logic ecin);
    int k;
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    k = 0;
    while (!cur_ir && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    lat = 1;
    n_exec = 0;
    stable = 1'b1;
    ea = cur_a;
    eb = cur_b;
    eop = cur_op;
    ecin = cur_cin;
    while (!cur_rv && lat < 60) begin
      n_exec++;
      if (cur_a !== ea || cur_b !== eb || cur_op !== eop || cur_cin !== ecin) stable = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!cur_rv) lat = -1;
    d = cur_d;
    f = cur_f;
    e = cur_err;
    if (!hold) begin
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
    end
  endtask

  task automatic run(input logic [15:0] w, output logic [7:0] d, output logic [2:0] f);
    logic e, ecin;
    int lat, n;
    bit st;
    logic [7:0] ea, eb;
    logic [4:0] eop;
    issue(w, 1'b0, d, f, e, lat, n, st, ea, eb, eop, ecin);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sel = 1'b0;
    instr_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    tests_run++;
    if (cur_ir !== 1'b0 || cur_rv !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_handshake: instr_ready=%b rsp_valid=%b, required 0 0", cur_ir, cur_rv);
    end
    tests_run++;
    if ({cur_a, cur_b, cur_op, cur_cin} !== 22'd0) begin
      tests_failed++;
      $display("FAIL reset_alu_drive: a=%h b=%h op=%h cin=%b, required all 0", cur_a, cur_b, cur_op, cur_cin);
    end
    tests_run++;
    if ({cur_d, cur_f, cur_err, cur_st} !== 14'd0) begin
      tests_failed++;
      $display("FAIL reset_rsp: data=%h flags=%b err=%b state=%0d, required all 0", cur_d, cur_f, cur_err, cur_st);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (cur_ir !== 1'b1 || cur_st !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_idle_ready: instr_ready=%b state=%0d, required 1 0", cur_ir, cur_st);
    end
  endtask

  task automatic test_add_basic();
    logic [7:0] d, ea, eb;
    logic [2:0] f;
    logic e, ecin;
    logic [4:0] eop;
    int lat, n;
    bit st;
    sel = 1'b0;
    apply_reset();
    issue(enc_ldi(2'd1, 8'h7F), 1'b0, d, f, e, lat, n, st, ea, eb, eop, ecin);
    tests_run++;
    if (lat !== 1 || d !== 8'h7F || e !== 1'b0 || f !== 3'b000) begin
      tests_failed++;
      $display("FAIL ldi_r1: lat=%0d data=%h err=%b flags=%b, required 1 7f 0 000", lat, d, e, f);
    end
    run(enc_ldi(2'd2, 8'h01), d, f);
    issue(enc(5'd0, 2'd3, 2'd1, 2'd2), 1'b0, d, f, e, lat, n, st, ea, eb, eop, ecin);
    tests_run++;
    if (lat !== 2) begin
      tests_failed++;
      $display("FAIL add_latency: got %0d edges, required 2", lat);
    end
    tests_run++;
    if (ea !== 8'h7F || eb !== 8'h01 || eop !== 5'd0) begin
      tests_failed++;
      $display("FAIL add_operands: a=%h b=%h op=%0d, required 7f 01 0", ea, eb, eop);
    end
    tests_run++;
    if (d !== 8'h80 || f !== 3'b001 || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_result: data=%h flags=%b err=%b, required 80 001 0", d, f, e);
    end
    run(enc(5'd0, 2'd3, 2'd3, 2'd0), d, f);
    tests_run++;
    if (d !== 8'h80) begin
      tests_failed++;
      $display("FAIL add_writeback_r3: got %h, required 80", d);
    end
  endtask

  task automatic test_carry_chain();
    logic [7:0] d, ea, eb;
    logic [2:0] f;
    logic e, ecin;
    logic [4:0] eop;
    int lat, n;
    bit st;
    sel = 1'b0;
    apply_reset();
    run(enc_ldi(2'd0, 8'hFF), d, f);
    run(enc_ldi(2'd1, 8'h01), d, f);
    issue(enc(5'd0, 2'd2, 2'd0, 2'd1), 1'b0, d, f, e, lat, n, st, ea, eb, eop, ecin);
    tests_run++;
    if (d !== 8'h00 || f !== 3'b110) begin
      tests_failed++;
      $display("FAIL carry_wrap: data=%h flags=%b, required 00 110", d, f);
    end
    issue(enc(5'd2, 2'd3, 2'd1, 2'd1), 1'b0, d, f, e, lat, n, st, ea, eb, eop, ecin);
    tests_run++;
    if (ecin !== 1'b1 || eop !== 5'd2) begin
      tests_failed++;
      $display("FAIL carry_cin_drive: cin=%b op=%0d, required 1 2", ecin, eop);
    end
    tests_run++;
    if (d !== 8'h03 || f !== 3'b000) begin
      tests_failed++;
      $display("FAIL carry_adc_result: data=%h flags=%b, required 03 000", d, f);
    end
  endtask

  task automatic test_illegal();
    logic [7:0] d, ea, eb;
    logic [2:0] f;
    logic e, ecin;
    logic [4:0] eop;
    int lat, n;
    bit st;
    sel = 1'b0;
    apply_reset();
    run(enc_ldi(2'd1, 8'h01), d, f);
    run(enc_ldi(2'd0, 8'hFF), d, f);
    run(enc(5'd0, 2'd2, 2'd0, 2'd1), d, f);
    issue(enc(5'd28, 2'd1, 2'd0, 2'd0), 1'b0, d, f, e, lat, n, st, ea, eb, eop, ecin);
    tests_run++;
    if (e !== 1'b1 || d !== 8'h00 || f !== 3'b110) begin
      tests_failed++;
      $display("FAIL illegal_rsp: err=%b data=%h flags=%b, required 1 00 110", e, d, f);
    end
    tests_run++;
    if (lat !== 1 || n !== 0 || eop !== 5'd0) begin
      tests_failed++;
      $display("FAIL illegal_no_exec: lat=%0d exec_cycles=%0d op=%0d, required 1 0 0", lat, n, eop);
    end
    run(enc_ldi(2'd0, 8'h00), d, f);
    tests_run++;
    if (f !== 3'b110) begin
      tests_failed++;
      $display("FAIL ldi_keeps_flags: got %b, required 110", f);
    end
    run(enc(5'd0, 2'd1, 2'd1, 2'd0), d, f);
    tests_run++;
    if (d !== 8'h01) begin
      tests_failed++;
      $display("FAIL illegal_no_write_r1: got %h, required 01", d);
    end
  endtask

  task automatic test_exec4();
    logic [7:0] d, ea, eb;
    logic [2:0] f;
    logic e, ecin;
    logic [4:0] eop;
    int lat, n;
    bit st;
    sel = 1'b1;
    apply_reset();
    run(enc_ldi(2'd1, 8'h0A), d, f);
    issue(enc(5'd4, 2'd1, 2'd1, 2'd1), 1'b0, d, f, e, lat, n, st, ea, eb, eop, ecin);
    tests_run++;
    if (lat !== 5 || n !== 4) begin
      tests_failed++;
      $display("FAIL exec4_timing: lat=%0d exec_cycles=%0d, required 5 4", lat, n);
    end
    tests_run++;
    if (st !== 1'b1 || ea !== 8'h0A || eb !== 8'h0A || eop !== 5'd4) begin
      tests_failed++;
      $display("FAIL exec4_operands: stable=%b a=%h b=%h op=%0d, required 1 0a 0a 4", st, ea, eb, eop);
    end
    tests_run++;
    if (d !== 8'h64) begin
      tests_failed++;
      $display("FAIL exec4_result: got %h, required 64", d);
    end
    run(enc(5'd0, 2'd2, 2'd1, 2'd0), d, f);
    tests_run++;
    if (d !== 8'h64) begin
      tests_failed++;
      $display("FAIL exec4_writeback_r1: got %h, required 64", d);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] d, ea, eb;
    logic [2:0] f;
    logic e, ecin;
    logic [4:0] eop;
    int lat, n;
    bit st;
    sel = 1'b0;
    apply_reset();
    run(enc_ldi(2'd2, 8'h55), d, f);
    issue(enc(5'd0, 2'd3, 2'd2, 2'd0), 1'b1, d, f, e, lat, n, st, ea, eb, eop, ecin);
    tests_run++;
    if (lat !== 2 || d !== 8'h55) begin
      tests_failed++;
      $display("FAIL bp_first: lat=%0d data=%h, required 2 55", lat, d);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 3) begin
        instr = enc_ldi(2'd2, 8'h11);
        instr_valid = 1'b1;
      end else begin
        instr_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (cur_rv !== 1'b1 || cur_d !== 8'h55 || cur_ir !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_stall cycle %0d: rsp_valid=%b data=%h instr_ready=%b, required 1 55 0", c, cur_rv, cur_d, cur_ir);
      end
    end
    @(negedge clk);
    instr_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    tests_run++;
    if (cur_rv !== 1'b0 || cur_ir !== 1'b1 || cur_st !== 2'd0) begin
      tests_failed++;
      $display("FAIL bp_release: rsp_valid=%b instr_ready=%b state=%0d, required 0 1 0", cur_rv, cur_ir, cur_st);
    end
    run(enc(5'd0, 2'd2, 2'd2, 2'd0), d, f);
    tests_run++;
    if (d !== 8'h55) begin
      tests_failed++;
      $display("FAIL bp_pulse_ignored_r2: got %h, required 55", d);
    end
  endtask

  task automatic test_reset_mid_exec();
    logic [7:0] d;
    logic [2:0] f;
    int seen;
    sel = 1'b1;
    apply_reset();
    run(enc_ldi(2'd1, 8'h05), d, f);
    run(enc_ldi(2'd2, 8'h06), d, f);
    @(negedge clk);
    instr = enc(5'd0, 2'd3, 2'd1, 2'd2);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (cur_st !== 2'd1 || cur_a !== 8'h05 || cur_b !== 8'h06) begin
      tests_failed++;
      $display("FAIL rst_mid_pre: state=%0d a=%h b=%h, required 1 05 06", cur_st, cur_a, cur_b);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (cur_st !== 2'd0 || cur_rv !== 1'b0 || cur_ir !== 1'b0 || cur_a !== 8'h00 || cur_op !== 5'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_async: state=%0d rsp_valid=%b ready=%b a=%h op=%0d, required 0 0 0 00 0", cur_st, cur_rv, cur_ir, cur_a, cur_op);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (cur_rv) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("FAIL rst_mid_no_rsp: rsp_valid high %0d cycles, required 0", seen);
    end
    run(enc_ldi(2'd1, 8'h05), d, f);
    run(enc(5'd0, 2'd3, 2'd3, 2'd0), d, f);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL rst_mid_r3_cleared: got %h, required 00", d);
    end
    run(enc(5'd0, 2'd2, 2'd2, 2'd0), d, f);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL rst_mid_r2_cleared: got %h, required 00", d);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b1;
    sel = 1'b0;
    instr = 16'd0;
    instr_valid = 1'b0;
    rsp_ready = 1'b0;
    test_reset();
    test_add_basic();
    test_carry_chain();
    test_illegal();
    test_exec4();
    test_backpressure();
    test_reset_mid_exec();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-side initiator for the 8-bit combinational ALU: accepts 16-bit instruction words over a valid/ready handshake and keeps a small register file plus a carry/zero/overflow flag register.
- Drives the ALU operand, opcode and carry-in pins, holds them stable for a programmable number of cycles, then captures result and flags.
- Writes the result back to the register file and returns it over a valid/ready response channel.
- Sits between an instruction source (bench, microcontroller FSM) and the ALU instance.

Parameters:
- DW, 8, datapath width; must match the ALU operand width.
- REG_AW, 2, register-file address width; 2**REG_AW registers.
- EXEC_CYCLES, 1, cycles the ALU inputs are held before capture; range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  instruction word present.
- instr_ready  output  1  sequencer can accept an instruction.
- instr  input  16  [15:11] opcode, [10:9] rd, [8:7] rs1, [6:5] rs2; for opcode 31, [7:0] is an immediate.
- alu_a  output  DW  ALU operand a.
- alu_b  output  DW  ALU operand b.
- alu_cin  output  1  ALU carry-in, equal to the stored C flag.
- alu_opcode  output  5  ALU opcode.
- alu_result  input  DW  ALU result.
- alu_cout  input  1  ALU carry out.
- alu_z  input  1  ALU zero flag.
- alu_v  input  1  ALU overflow flag.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumer ready.
- rsp_data  output  DW  written-back value.
- rsp_flags  output  3  {C,Z,V} after the instruction.
- rsp_err  output  1  illegal opcode.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - All registers, C/Z/V, counter and captured instruction cleared.
  - instr_ready=0 while rst_n=0, then 1 in IDLE.
  - rsp_valid, rsp_data, rsp_flags, rsp_err, alu_a, alu_b, alu_cin and alu_opcode all 0.
- States IDLE, EXEC, RSP:
  - IDLE: instr_ready=1. A handshake (instr_valid & instr_ready at a clock edge) latches instr.
    - Opcode 0..26: go to EXEC, counter=EXEC_CYCLES-1.
    - Opcode 31 (LDI): go to RSP. reg[rd] is written with instr[7:0] at that edge. rsp_data=imm, flags unchanged, rsp_err=0.
    - Opcode 27..30: go to RSP. No write, flags unchanged, rsp_data=0, rsp_err=1.
  - EXEC: instr_ready=0.
    - Driven outputs: alu_a=reg[rs1], alu_b=reg[rs2], alu_opcode=latched opcode, alu_cin=C. All are registered-stable for the whole state.
    - Counter decrements each cycle. On the edge where counter==0:
      - reg[rd] <= alu_result; {C,Z,V} <= {alu_cout,alu_z,alu_v}.
      - rsp_data <= alu_result; rsp_flags <= new flags; rsp_err <= 0.
      - Go to RSP.
  - RSP: rsp_valid=1; rsp_data, rsp_flags and rsp_err are held stable. On rsp_valid & rsp_ready, go to IDLE. rsp_ready is ignored in other states.
- ALU drive outside EXEC: all ALU outputs driven to 0 in IDLE and RSP.
- Latency: handshake edge to rsp_valid high is EXEC_CYCLES+1 edges for ALU ops and 1 edge for LDI or an illegal opcode. Minimum issue interval is EXEC_CYCLES+2 cycles.
- Operand hazards: rd may equal rs1 and/or rs2. Operands are read before write-back, so the old value is used. The next instruction sees the new value.
- Flag usage: C feeds alu_cin for every ALU op. Opcodes 2, 3, 25 and 26 therefore chain carry across instructions.
- Compare ops (18..20): a 0/1 result is written to rd.
- Back-pressure: rsp_ready held low stalls in RSP indefinitely with outputs unchanged. No instruction is accepted meanwhile.
- Reset mid-EXEC or mid-RSP:
  - The instruction is abandoned with no write-back.
  - rsp_valid drops immediately, since reset is asynchronous.
  - The register file is cleared.
- X on alu_result outside EXEC is never sampled.

Test Plan:
- Reset, then LDI r1=0x7F and LDI r2=0x01, then op0 r3=r1+r2 (EXEC_CYCLES=1) -> rsp_valid 2 edges after handshake, rsp_data=0x80, reg r3=0x80.
- LDI r0=0xFF, LDI r1=0x01, op0 r2=r0+r1 -> rsp_data=0x00, rsp_flags C=1, Z=1. Then op2 r3=r1+r1 -> alu_cin=1 during EXEC, rsp_data=0x03.
- Illegal opcode 28 -> rsp_err=1 one edge after handshake, rsp_data=0, flags and registers unchanged, no EXEC cycle (alu_opcode stays 0).
- EXEC_CYCLES=4, op4 r1=r1*r1 with r1=0x0A -> alu_a=alu_b=0x0A stable for 4 cycles, rsp_data=0x64, then r1=0x64.
- rsp_ready held 0 for 10 cycles -> rsp_valid and rsp_data constant, instr_ready=0; the instr_valid pulse is not accepted; rsp_ready=1 -> IDLE the next cycle.
- rst_n asserted during EXEC of op0 r3=r1+r2 -> immediate return to reset state, r3 not written (reads 0 via a later op with r0 after re-LDI), rsp_valid never asserted.
